rob: RTL and testbench

Eight-entry reorder buffer that sits directly downstream of the `cdb` arbiter in the Tomasulo core. It allocates a tag to each dispatched instruction and captures the single broadcast result per cycle from the CDB. It exposes completed operand values to dispatch and retires finished instructions strictly in program order, one per cycle, to the architectural register file.

---
 rtl/rob_pkg.sv | 49 ++++
 rtl/rob.sv | 129 ++++++++++++
 tb/tb_rob.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Shared types for the reorder buffer: entry layout, commit packet and the
// operand lookup helper used by both dispatch read ports.
package rob_pkg;

    localparam int XLEN      = 32;
    localparam int ROB_DEPTH = 8;
    localparam int TAG_W     = $clog2(ROB_DEPTH);
    localparam int CNT_W     = TAG_W + 1;

    typedef logic [TAG_W-1:0] rob_tag_t;

    typedef struct packed {
        logic            valid;
        logic            done;
        logic            has_dest;
        logic [4:0]      dest_reg;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] value;
    } rob_entry_t;

    typedef struct packed {
        logic            valid;
        logic            wr_en;
        logic [4:0]      dest_reg;
        logic [XLEN-1:0] value;
        logic [XLEN-1:0] pc;
        rob_tag_t        tag;
    } rob_commit_t;

    typedef struct packed {
        logic            ready;
        logic [XLEN-1:0] value;
    } rob_read_t;

    // A same-cycle CDB write to a live entry wins over the stored value.
    function automatic rob_read_t rob_lookup(input rob_entry_t      e,
                                             input rob_tag_t        tag,
                                             input logic            cdb_valid,
                                             input rob_tag_t        cdb_tag,
                                             input logic [XLEN-1:0] cdb_value);
        rob_read_t r;
        logic      bypass;
        bypass  = cdb_valid && (cdb_tag == tag) && e.valid;
        r.ready = (e.valid && e.done) || bypass;
        r.value = bypass ? cdb_value : e.value;
        return r;
    endfunction

endpackage

// File: rtl/rob.sv
// Eight-entry reorder buffer: allocates tags at dispatch, captures CDB results,
// serves operand reads with CDB bypass and retires in program order.
module rob
    import rob_pkg::*;
(
    input  logic            clock,
    input  logic            reset_n,
    input  logic            dispatch_valid,
    input  logic            dispatch_has_dest,
    input  logic [4:0]      dispatch_dest_reg,
    input  logic [XLEN-1:0] dispatch_pc,
    output logic            dispatch_ready,
    output rob_tag_t        dispatch_tag,
    input  logic            cdb_valid,
    input  rob_tag_t        cdb_tag,
    input  logic [XLEN-1:0] cdb_value,
    input  rob_tag_t        rd_tag_a,
    input  rob_tag_t        rd_tag_b,
    output logic            rd_ready_a,
    output logic            rd_ready_b,
    output logic [XLEN-1:0] rd_value_a,
    output logic [XLEN-1:0] rd_value_b,
    input  logic            flush,
    output logic            commit_valid,
    output logic            commit_wr_en,
    output logic [4:0]      commit_dest_reg,
    output logic [XLEN-1:0] commit_value,
    output logic [XLEN-1:0] commit_pc,
    output rob_tag_t        commit_tag,
    output logic            rob_empty,
    output logic [CNT_W-1:0] rob_count
);

    rob_entry_t       entries [ROB_DEPTH];
    rob_tag_t         head;
    rob_tag_t         tail;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             ready_q;
    logic             do_dispatch;
    logic             do_commit;
    logic             cdb_hit;
    rob_commit_t      commit_pkt;
    rob_read_t        read_a;
    rob_read_t        read_b;

    assign do_dispatch = dispatch_valid && ready_q;
    assign cdb_hit     = cdb_valid && entries[cdb_tag].valid;

    always_comb begin
        commit_pkt          = '0;
        commit_pkt.valid    = entries[head].valid && entries[head].done;
        commit_pkt.wr_en    = commit_pkt.valid && entries[head].has_dest;
        commit_pkt.dest_reg = entries[head].dest_reg;
        commit_pkt.value    = entries[head].value;
        commit_pkt.pc       = entries[head].pc;
        commit_pkt.tag      = head;
    end

    assign do_commit = commit_pkt.valid;
    assign count_nxt = count + CNT_W'(do_dispatch) - CNT_W'(do_commit);

    // Dispatch write comes last so it wins over stale CDB/commit updates to tail.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < ROB_DEPTH; i++) entries[i] <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            ready_q <= 1'b1;
        end else if (flush) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries[i].valid <= 1'b0;
                entries[i].done  <= 1'b0;
            end
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            ready_q <= 1'b1;
        end else begin
            if (cdb_hit) begin
                entries[cdb_tag].done  <= 1'b1;
                entries[cdb_tag].value <= cdb_value;
            end
            if (do_commit) begin
                entries[head].valid <= 1'b0;
                head                <= head + 1'b1;
            end
            if (do_dispatch) begin
                entries[tail].valid    <= 1'b1;
                entries[tail].done     <= 1'b0;
                entries[tail].has_dest <= dispatch_has_dest;
                entries[tail].dest_reg <= dispatch_dest_reg;
                entries[tail].pc       <= dispatch_pc;
                entries[tail].value    <= '0;
                tail                   <= tail + 1'b1;
            end
            count   <= count_nxt;
            ready_q <= (count_nxt != CNT_W'(ROB_DEPTH));
        end
    end

`ifndef SYNTHESIS
    always @(posedge clock) begin
        if (reset_n && cdb_valid && !entries[cdb_tag].valid)
            $error("rob: CDB broadcast to invalid entry %0d", cdb_tag);
    end
`endif

    assign read_a = rob_lookup(entries[rd_tag_a], rd_tag_a, cdb_valid, cdb_tag, cdb_value);
    assign read_b = rob_lookup(entries[rd_tag_b], rd_tag_b, cdb_valid, cdb_tag, cdb_value);

    assign rd_ready_a      = read_a.ready;
    assign rd_value_a      = read_a.value;
    assign rd_ready_b      = read_b.ready;
    assign rd_value_b      = read_b.value;

    assign dispatch_ready  = ready_q;
    assign dispatch_tag    = tail;
    assign commit_valid    = commit_pkt.valid;
    assign commit_wr_en    = commit_pkt.wr_en;
    assign commit_dest_reg = commit_pkt.dest_reg;
    assign commit_value    = commit_pkt.value;
    assign commit_pc       = commit_pkt.pc;
    assign commit_tag      = commit_pkt.tag;
    assign rob_empty       = (count == '0);
    assign rob_count       = count;

endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: allocation, out-of-order completion, full/wrap,
// bypass, no-dest commit, flush priority and mid-stream reset.
module tb_rob;
    import rob_pkg::*;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            dispatch_valid;
    logic            dispatch_has_dest;
    logic [4:0]      dispatch_dest_reg;
    logic [XLEN-1:0] dispatch_pc;
    logic            dispatch_ready;
    rob_tag_t        dispatch_tag;
    logic            cdb_valid;
    rob_tag_t        cdb_tag;
    logic [XLEN-1:0] cdb_value;
    rob_tag_t        rd_tag_a;
    rob_tag_t        rd_tag_b;
    logic            rd_ready_a;
    logic            rd_ready_b;
    logic [XLEN-1:0] rd_value_a;
    logic [XLEN-1:0] rd_value_b;
    logic            flush;
    logic            commit_valid;
    logic            commit_wr_en;
    logic [4:0]      commit_dest_reg;
    logic [XLEN-1:0] commit_value;
    logic [XLEN-1:0] commit_pc;
    rob_tag_t        commit_tag;
    logic            rob_empty;
    logic [CNT_W-1:0] rob_count;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    always #5 clock = ~clock;

    rob dut (
        .clock(clock), .reset_n(reset_n),
        .dispatch_valid(dispatch_valid), .dispatch_has_dest(dispatch_has_dest),
        .dispatch_dest_reg(dispatch_dest_reg), .dispatch_pc(dispatch_pc),
        .dispatch_ready(dispatch_ready), .dispatch_tag(dispatch_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .rd_tag_a(rd_tag_a), .rd_tag_b(rd_tag_b),
        .rd_ready_a(rd_ready_a), .rd_ready_b(rd_ready_b),
        .rd_value_a(rd_value_a), .rd_value_b(rd_value_b),
        .flush(flush),
        .commit_valid(commit_valid), .commit_wr_en(commit_wr_en),
        .commit_dest_reg(commit_dest_reg), .commit_value(commit_value),
        .commit_pc(commit_pc), .commit_tag(commit_tag),
        .rob_empty(rob_empty), .rob_count(rob_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        dispatch_valid = 1'b0; dispatch_has_dest = 1'b0;
        dispatch_dest_reg = '0; dispatch_pc = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
        flush = 1'b0;
    endtask

    task automatic set_dispatch(input logic has_dest, input logic [4:0] rd, input logic [31:0] pc);
        dispatch_valid = 1'b1; dispatch_has_dest = has_dest;
        dispatch_dest_reg = rd; dispatch_pc = pc;
    endtask

    task automatic set_cdb(input rob_tag_t t, input logic [31:0] v);
        cdb_valid = 1'b1; cdb_tag = t; cdb_value = v;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        rd_tag_a = '0; rd_tag_b = '0;
        reset_n = 1'b0;
        tick();
        do_reset();

        // reset state
        chk("rst_ready", dispatch_ready, 1);
        chk("rst_empty", rob_empty, 1);
        chk("rst_count", rob_count, 0);
        chk("rst_cvalid", commit_valid, 0);
        chk("rst_wren", commit_wr_en, 0);
        chk("rst_tag", dispatch_tag, 0);
        chk("rst_rdy_a", rd_ready_a, 0);
        chk("rst_rdy_b", rd_ready_b, 0);
        chk("rst_val_a", rd_value_a, 0);
        chk("rst_cpc", commit_pc, 0);
        chk("rst_cval", commit_value, 0);

        // basic allocation x5, x6, x7
        for (int i = 0; i < 3; i++) begin
            set_dispatch(1'b1, 5'(5 + i), 32'h100 + 32'(4 * i));
            settle();
            chk("alloc_tag", dispatch_tag, i);
            tick();
        end
        idle_inputs();
        settle();
        chk("alloc_count", rob_count, 3);
        chk("alloc_cvalid", commit_valid, 0);

        // out-of-order completion, in-order commit
        set_cdb(3'd2, 32'd30);
        tick();
        chk("ooo_no_commit", commit_valid, 0);
        set_cdb(3'd0, 32'd10);
        tick();
        set_cdb(3'd1, 32'd20);
        settle();
        chk("ooo_c0_valid", commit_valid, 1);
        chk("ooo_c0_reg", commit_dest_reg, 5);
        chk("ooo_c0_val", commit_value, 10);
        chk("ooo_c0_pc", commit_pc, 32'h100);
        chk("ooo_c0_wren", commit_wr_en, 1);
        tick();
        idle_inputs();
        settle();
        chk("ooo_c1_valid", commit_valid, 1);
        chk("ooo_c1_reg", commit_dest_reg, 6);
        chk("ooo_c1_val", commit_value, 20);
        chk("ooo_c1_tag", commit_tag, 1);
        tick();
        chk("ooo_c2_valid", commit_valid, 1);
        chk("ooo_c2_reg", commit_dest_reg, 7);
        chk("ooo_c2_val", commit_value, 30);
        tick();
        chk("ooo_drained", rob_empty, 1);
        chk("ooo_none", commit_valid, 0);

        // full and wrap-around; entry 1 has no destination
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_dispatch(i != 1, 5'(i + 1), 32'h200 + 32'(4 * i));
            tick();
        end
        chk("full_ready", dispatch_ready, 0);
        chk("full_count", rob_count, 8);
        set_dispatch(1'b1, 5'd31, 32'hBAD);
        tick();
        chk("full_9th_count", rob_count, 8);
        chk("full_9th_tag", dispatch_tag, 0);
        idle_inputs();

        // same-cycle CDB bypass on port a, stored value on port b
        rd_tag_a = 3'd3; rd_tag_b = 3'd4;
        settle();
        chk("byp_pre_rdy", rd_ready_a, 0);
        set_cdb(3'd3, 32'hDEAD);
        settle();
        chk("byp_rdy_a", rd_ready_a, 1);
        chk("byp_val_a", rd_value_a, 32'hDEAD);
        chk("byp_rdy_b", rd_ready_b, 0);
        tick();
        idle_inputs();
        settle();
        chk("byp_stored_rdy", rd_ready_a, 1);
        chk("byp_stored_val", rd_value_a, 32'hDEAD);

        // commit tag0 while full; dispatch that cycle is ignored
        set_cdb(3'd0, 32'h11);
        tick();
        idle_inputs();
        set_dispatch(1'b1, 5'd20, 32'h300);
        settle();
        chk("wrap_c0_valid", commit_valid, 1);
        chk("wrap_c0_val", commit_value, 32'h11);
        chk("wrap_ready_low", dispatch_ready, 0);
        tick();
        chk("wrap_count7", rob_count, 7);
        chk("wrap_ready_hi", dispatch_ready, 1);
        chk("wrap_tag0", dispatch_tag, 0);
        tick();
        idle_inputs();
        chk("wrap_count8", rob_count, 8);

        // no-dest commit of tag1
        set_cdb(3'd1, 32'h22);
        tick();
        idle_inputs();
        settle();
        chk("nodest_valid", commit_valid, 1);
        chk("nodest_wren", commit_wr_en, 0);
        chk("nodest_tag", commit_tag, 1);
        tick();
        chk("nodest_count", rob_count, 7);

        // flush beats dispatch and CDB in the same cycle
        set_dispatch(1'b1, 5'd9, 32'h400);
        set_cdb(3'd2, 32'h33);
        flush = 1'b1;
        tick();
        idle_inputs();
        chk("flush_empty", rob_empty, 1);
        chk("flush_count", rob_count, 0);
        chk("flush_tag", dispatch_tag, 0);
        chk("flush_ready", dispatch_ready, 1);
        chk("flush_cvalid", commit_valid, 0);
        rd_tag_a = 3'd3;
        settle();
        chk("flush_rd_a", rd_ready_a, 0);
        tick(); tick();
        chk("flush_no_commit", commit_valid, 0);

        // reset mid-stream with 4 live entries, 2 done
        for (int i = 0; i < 4; i++) begin
            set_dispatch(1'b1, 5'(10 + i), 32'h500 + 32'(4 * i));
            tick();
        end
        idle_inputs();
        set_cdb(3'd1, 32'h44);
        tick();
        set_cdb(3'd2, 32'h55);
        tick();
        idle_inputs();
        chk("mid_count", rob_count, 4);
        do_reset();
        rd_tag_a = 3'd1; rd_tag_b = 3'd2;
        settle();
        chk("mid_empty", rob_empty, 1);
        chk("mid_count0", rob_count, 0);
        chk("mid_ready", dispatch_ready, 1);
        chk("mid_cvalid", commit_valid, 0);
        chk("mid_rdy_a", rd_ready_a, 0);
        chk("mid_val_b", rd_value_b, 0);

        // quickest dispatch-to-commit after reset: two edges
        set_dispatch(1'b1, 5'd3, 32'h600);
        tick();
        idle_inputs();
        set_cdb(3'd0, 32'h66);
        tick();
        idle_inputs();
        chk("post_cvalid", commit_valid, 1);
        chk("post_cval", commit_value, 32'h66);
        chk("post_cpc", commit_pc, 32'h600);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
